// File: rtl/alu_muldiv.sv
// Single-cycle ALU with a shared iterative multiply/divide unit driving HI/LO.
// Logic ops finish at the accepting edge; MULT/DIV take WIDTH iterations in RUN.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic [3:0]       alucontrol,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, next_state;

   logic signed [WIDTH-1:0] a_s, b_s;
   logic                    accept, is_long, a_neg, b_neg, last;
   logic [CW-1:0]           count;
   logic [WIDTH-1:0]        alu_res;

   logic                    op_div, div_zero, neg_lo, neg_hi;
   logic [WIDTH-1:0]        a_raw, opnd, acc_hi, acc_lo;
   logic [WIDTH:0]          add_sum, shifted, diff;
   logic                    ge;
   logic [WIDTH-1:0]        it_hi, it_lo, fin_hi, fin_lo;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                                input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0011: return a ^ b;
         4'b0100: return ~(a | b);
         4'b0110: return a - b;
         4'b0111: return WIDTH'(a < b);
         4'b0101: return WIDTH'($unsigned(a) < $unsigned(b));
         default: return '0;
      endcase
   endfunction

   assign a_s     = srca;
   assign b_s     = srcb;
   assign is_long = (alucontrol[3:2] == 2'b10);
   assign a_neg   = ~alucontrol[0] && (a_s < 0);
   assign b_neg   = ~alucontrol[0] && (b_s < 0);
   assign alu_res = alu_op(alucontrol, a_s, b_s);
   assign accept  = start && !busy;
   assign last    = busy && (count == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start && is_long) next_state = RUN;
         RUN:  if (count == CW'(1))  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
   end

   // One iteration: shift-add for multiply, restoring shift-subtract for divide.
   // The remainder stays below the divisor, so diff's MSB is a clean borrow bit.
   always_comb begin
      add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      ge      = ~diff[WIDTH];
      if (op_div) begin
         it_hi = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         it_lo = {acc_lo[WIDTH-2:0], ge};
      end else begin
         it_hi = add_sum[WIDTH:1];
         it_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   // Signs are restored only after the magnitude iterations finish.
   always_comb begin
      {fin_hi, fin_lo} = cond_neg2({it_hi, it_lo}, neg_lo);
      if (op_div) begin
         if (div_zero) begin
            fin_hi = a_raw;
            fin_lo = '1;
         end else begin
            fin_hi = cond_neg(it_hi, neg_hi);
            fin_lo = cond_neg(it_lo, neg_lo);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && is_long) begin
         op_div   <= alucontrol[1];
         a_raw    <= srca;
         div_zero <= (srcb == '0);
         neg_lo   <= a_neg ^ b_neg;
         neg_hi   <= a_neg;
         acc_hi   <= '0;
         if (alucontrol[1]) begin
            acc_lo <= cond_neg(srca, a_neg);
            opnd   <= cond_neg(srcb, b_neg);
         end else begin
            acc_lo <= cond_neg(srcb, b_neg);
            opnd   <= cond_neg(srca, a_neg);
         end
      end else if (busy) begin
         acc_hi <= it_hi;
         acc_lo <= it_lo;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         zero   <= 1'b1;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         count  <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            if (is_long) begin
               count <= CW'(WIDTH);
            end else begin
               result <= alu_res;
               zero   <= (alu_res == '0);
               done   <= 1'b1;
            end
         end else if (busy) begin
            count <= count - CW'(1);
            if (last) begin
               hi     <= fin_hi;
               lo     <= fin_lo;
               result <= fin_lo;
               zero   <= (fin_lo == '0);
               done   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal values 8..64, must be even.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request; sampled only when busy=0.
REQ-005 Port: srca  input  WIDTH  operand A, captured on an accepted start.
REQ-006 Port: srcb  input  WIDTH  operand B, captured on an accepted start.
REQ-007 Port: alucontrol  input  4  opcode, captured on an accepted start.
REQ-008 Port: result  output  WIDTH  registered result of the last completed operation.
REQ-009 Port: zero  output  1  registered; 1 when result==0.
REQ-010 Port: busy  output  1  1 while a multi-cycle operation is in progress.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: hi  output  WIDTH  HI register, updated by MULT/DIV only.
REQ-013 Port: lo  output  WIDTH  LO register, updated by MULT/DIV only.

Function
REQ-014 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT (signed), 0101 SLTU, 1000 MULT (signed), 1001 MULTU, 1010 DIV (signed), 1011 DIVU; all others give result=0.
REQ-015 ADD/SUB wrap modulo 2^WIDTH; no overflow flag is produced.
REQ-016 SLT/SLTU give result={WIDTH-1 zeros, lt}.
REQ-017 FSM states: IDLE and RUN; reset enters IDLE.
REQ-018 Accepted start: start=1 and busy=0 at a rising edge k.
REQ-019 Single-cycle op accepted at edge k: result and zero update at edge k; done=1 for exactly the cycle after edge k; FSM stays IDLE; busy stays 0.
REQ-020 MULT/DIV accepted at edge k: FSM goes IDLE->RUN and loads an iteration counter with WIDTH.
REQ-021 In RUN, busy=1 from edge k through edge k+WIDTH, i.e. exactly WIDTH cycles.
REQ-022 In RUN, one iteration executes per edge: shift-add for multiply, restoring shift-subtract for divide.
REQ-023 At edge k+WIDTH the FSM returns RUN->IDLE; at that edge hi, lo, result (=lo) and zero update, and done=1 for the following cycle.
REQ-024 Multiply: {hi,lo} = full 2*WIDTH-bit product.
REQ-025 Multiply signedness: MULT treats both operands as two's complement; MULTU as unsigned.
REQ-026 Signed operations work internally on magnitudes; result signs are applied at completion.
REQ-027 Divide: lo = quotient, hi = remainder.
REQ-028 Signed divide truncates toward zero; the remainder takes the sign of the dividend.
REQ-029 Divide by zero: lo = all ones, hi = srca; completes in the same WIDTH cycles.
REQ-030 DIV overflow (srca = most-negative value, srcb = -1): lo = srca, hi = 0.
REQ-031 start while busy=1 is ignored: no capture and no effect on the operation in progress.
REQ-032 Operand or opcode changes after acceptance do not affect the operation in progress.
REQ-033 Back-to-back operation: start may be accepted in the same cycle done=1, since busy=0 then.
REQ-034 Between operations, result, zero, hi and lo hold their values.

Reset
REQ-035 Reset values: result=0, zero=1, hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0.
REQ-036 Reset has priority over start at the same edge.
REQ-037 Reset during RUN aborts the operation with no done pulse; the registers take their reset values.

Verification (WIDTH=32)
REQ-038 Single-cycle: ADD 0xFFFFFFFF+1 -> result=0, zero=1, done one cycle after start, busy never 1; SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0.
REQ-039 Multiply: MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE; done exactly 33 edges after start, busy high 32 cycles.
REQ-040 Divide: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-041 Handshake: start held high for 40 cycles with changing operands -> exactly one MULT is executed, with the first-captured operands; a second op is accepted on the done cycle.
REQ-042 Reset mid-op: reset asserted at iteration 10 of DIV -> no done pulse, all outputs at reset values on the next cycle, a new op then runs normally.
